// File: rtl/cart_pkg.sv
// ============================================================================
// Module      : cart_pkg
// Description : Shared types and constants for the cartridge bank-switch mapper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cart_pkg;

    typedef enum logic [2:0] {
        MAP_NONE = 3'd0,
        MAP_F8   = 3'd1,
        MAP_F6   = 3'd2,
        MAP_F4   = 3'd3
    } mapper_t;

    localparam logic [12:0] c_F8_HS_BASE  = 13'h1FF8;
    localparam logic [12:0] c_F8_HS_LIMIT = 13'h1FF9;
    localparam logic [12:0] c_F6_HS_BASE  = 13'h1FF6;
    localparam logic [12:0] c_F6_HS_LIMIT = 13'h1FF9;
    localparam logic [12:0] c_F4_HS_BASE  = 13'h1FF4;
    localparam logic [12:0] c_F4_HS_LIMIT = 13'h1FFB;

    localparam logic [12:0] c_SC_WR_BASE  = 13'h1000;
    localparam logic [12:0] c_SC_WR_LIMIT = 13'h107F;
    localparam logic [12:0] c_SC_RD_BASE  = 13'h1080;
    localparam logic [12:0] c_SC_RD_LIMIT = 13'h10FF;

    // Unassigned encodings fall back to the fixed (non-switching) image.
    function automatic mapper_t decode_mapper(input logic [2:0] i_m);
        mapper_t v;
        case (i_m)
            3'd1:    v = MAP_F8;
            3'd2:    v = MAP_F6;
            3'd3:    v = MAP_F4;
            default: v = MAP_NONE;
        endcase
        return v;
    endfunction

    // Carts boot from the last bank, where the reset vector lives.
    function automatic logic [2:0] reset_bank(input mapper_t i_m);
        logic [2:0] v;
        case (i_m)
            MAP_F8:  v = 3'd1;
            MAP_F6:  v = 3'd3;
            MAP_F4:  v = 3'd7;
            default: v = 3'd0;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cart_superchip_ram.sv
// ============================================================================
// Module      : cart_superchip_ram
// Description : 128x8 Superchip RAM, one write port and one registered read port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cart_superchip_ram (
    input  logic       clk,
    input  logic       i_we,
    input  logic [6:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [6:0] i_raddr,
    output logic [7:0] o_rdata
);

    logic [7:0] r_mem [0:127];
    logic [7:0] r_rdata;

    // Contents deliberately survive reset, as on the real cartridge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/cart_mapper.sv
// ============================================================================
// Module      : cart_mapper
// Description : Cartridge bank-switch mapper (2K/4K, F8, F6, F4, Superchip RAM).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cart_mapper
    import cart_pkg::*;
#(
    parameter int EXT_AW = 15,
    parameter int SC_EN  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_ce,
    input  logic [12:0]       cpu_addr,
    input  logic              cpu_rwn,
    input  logic [7:0]        cpu_wdata,
    input  logic [2:0]        mapper,
    input  logic              sc_en,
    output logic [EXT_AW-1:0] ext_addr,
    input  logic [7:0]        ext_rdata,
    output logic [7:0]        rom_rdata,
    output logic [2:0]        bank
);

    mapper_t     r_mapper_q;
    logic        r_sc_q;
    logic [2:0]  r_bank;
    logic        r_sc_sel;
    logic [7:0]  r_rom_rdata;

    logic        w_hs_hit;
    logic [2:0]  w_hs_base_lo;
    logic [2:0]  w_hs_bank;
    logic        w_hs_take;
    logic [14:0] w_ext15;
    logic        w_sc_wr_win;
    logic        w_sc_rd_win;
    logic        w_sc_we;
    logic [7:0]  w_ram_rdata;

    // Hotspot decode: the full 13-bit address must fall inside the scheme's range.
    always_comb begin
        w_hs_hit     = 1'b0;
        w_hs_base_lo = 3'd0;
        case (r_mapper_q)
            MAP_F8: begin
                w_hs_hit     = (cpu_addr >= c_F8_HS_BASE) && (cpu_addr <= c_F8_HS_LIMIT);
                w_hs_base_lo = c_F8_HS_BASE[2:0];
            end
            MAP_F6: begin
                w_hs_hit     = (cpu_addr >= c_F6_HS_BASE) && (cpu_addr <= c_F6_HS_LIMIT);
                w_hs_base_lo = c_F6_HS_BASE[2:0];
            end
            MAP_F4: begin
                w_hs_hit     = (cpu_addr >= c_F4_HS_BASE) && (cpu_addr <= c_F4_HS_LIMIT);
                w_hs_base_lo = c_F4_HS_BASE[2:0];
            end
            default: begin
                w_hs_hit     = 1'b0;
                w_hs_base_lo = 3'd0;
            end
        endcase
    end

    // No range spans more than 8 entries, so the offset is exact modulo 8.
    assign w_hs_bank = cpu_addr[2:0] - w_hs_base_lo;
    assign w_hs_take = cpu_ce && cpu_addr[12] && w_hs_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mapper_q <= decode_mapper(mapper);
            r_sc_q     <= sc_en & (SC_EN != 0);
            r_bank     <= reset_bank(decode_mapper(mapper));
        end else if (w_hs_take) begin
            r_bank     <= w_hs_bank;
        end
    end

    always_comb begin
        w_ext15 = {3'b000, cpu_addr[11:0]};
        case (r_mapper_q)
            MAP_F8:  w_ext15 = {2'b00, r_bank[0], cpu_addr[11:0]};
            MAP_F6:  w_ext15 = {1'b0, r_bank[1:0], cpu_addr[11:0]};
            MAP_F4:  w_ext15 = {r_bank, cpu_addr[11:0]};
            default: w_ext15 = {3'b000, cpu_addr[11:0]};
        endcase
    end

    assign ext_addr = EXT_AW'(w_ext15);

    assign w_sc_wr_win = r_sc_q && (cpu_addr >= c_SC_WR_BASE) && (cpu_addr <= c_SC_WR_LIMIT);
    assign w_sc_rd_win = r_sc_q && (cpu_addr >= c_SC_RD_BASE) && (cpu_addr <= c_SC_RD_LIMIT);
    assign w_sc_we     = w_sc_wr_win && cpu_ce && !cpu_rwn && !reset;

    generate
        if (SC_EN != 0) begin : g_sc_ram
            cart_superchip_ram u_sc_ram (
                .clk     (clk),
                .i_we    (w_sc_we),
                .i_waddr (cpu_addr[6:0]),
                .i_wdata (cpu_wdata),
                .i_raddr (cpu_addr[6:0]),
                .o_rdata (w_ram_rdata)
            );
        end else begin : g_no_sc_ram
            assign w_ram_rdata = 8'h00;
        end
    endgenerate

    // The select is delayed one clk to line up with the RAM's registered read,
    // giving both sources the same two-clk address-to-data latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sc_sel    <= 1'b0;
            r_rom_rdata <= 8'h00;
        end else begin
            r_sc_sel    <= w_sc_rd_win;
            r_rom_rdata <= r_sc_sel ? w_ram_rdata : ext_rdata;
        end
    end

    assign rom_rdata = r_rom_rdata;
    assign bank      = r_bank;

endmodule

`default_nettype wire

// File: tb/tb_cart_mapper.sv
// ============================================================================
// Module      : tb_cart_mapper
// Description : Self-checking bench for cart_mapper against a behavioural model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cart_mapper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_ce = 1'b0;
    logic [12:0] cpu_addr = 13'h0;
    logic        cpu_rwn = 1'b1;
    logic [7:0]  cpu_wdata = 8'h0;
    logic [2:0]  mapper = 3'd0;
    logic        sc_en = 1'b0;
    logic [14:0] ext_addr;
    logic [7:0]  ext_rdata = 8'h0;
    logic [7:0]  rom_rdata;
    logic [2:0]  bank;

    int n_chk  = 0;
    int n_fail = 0;

    int       m_map;
    int       m_bank;
    bit       m_sc;
    bit [7:0] m_ram   [128];
    bit       m_ram_v [128];

    cart_mapper #(.EXT_AW(15), .SC_EN(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_ce    (cpu_ce),
        .cpu_addr  (cpu_addr),
        .cpu_rwn   (cpu_rwn),
        .cpu_wdata (cpu_wdata),
        .mapper    (mapper),
        .sc_en     (sc_en),
        .ext_addr  (ext_addr),
        .ext_rdata (ext_rdata),
        .rom_rdata (rom_rdata),
        .bank      (bank)
    );

    always #5 clk = ~clk;

    // Synchronous external ROM whose contents depend on the bank bits too.
    function automatic logic [7:0] rom_byte(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
    endfunction

    always @(posedge clk) ext_rdata <= rom_byte(ext_addr);

    function automatic int n_banks(input int m);
        case (m)
            1: return 2;
            2: return 4;
            3: return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int hs_base(input int m);
        case (m)
            1: return 'h1FF8;
            2: return 'h1FF6;
            3: return 'h1FF4;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset(input int m, input bit s);
        mapper = 3'(m);
        sc_en  = s;
        reset  = 1'b1;
        cpu_ce = 1'b0;
        m_map  = (m <= 3) ? m : 0;
        m_sc   = s;
        m_bank = n_banks(m_map) - 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rdata", rom_rdata, 0);
        chk("rst_bank", bank, m_bank);
        reset = 1'b0;
    endtask

    // One CPU bus cycle: address held three clks, then a single cpu_ce strobe.
    task automatic bus(input int a, input bit rwn, input logic [7:0] wd, input bit ce);
        int ea;
        cpu_addr  = 13'(a);
        cpu_rwn   = rwn;
        cpu_wdata = wd;
        cpu_ce    = 1'b0;
        repeat (3) @(negedge clk);
        ea = m_bank * 4096 + (a % 4096);
        chk("ext_addr", ext_addr, ea);
        if (m_sc && a >= 'h1080 && a <= 'h10FF) begin
            if (m_ram_v[a % 128]) chk("sc_rdata", rom_rdata, m_ram[a % 128]);
        end else begin
            chk("rom_rdata", rom_rdata, rom_byte(15'(ea)));
        end
        cpu_ce = ce;
        @(negedge clk);
        cpu_ce = 1'b0;
        if (ce) begin
            if (a >= hs_base(m_map) && a < hs_base(m_map) + n_banks(m_map) && n_banks(m_map) > 1)
                m_bank = a - hs_base(m_map);
            if (m_sc && !rwn && a >= 'h1000 && a <= 'h107F) begin
                m_ram[a % 128]   = wd;
                m_ram_v[a % 128] = 1'b1;
            end
        end
        chk("bank", bank, m_bank);
    endtask

    task automatic rand_cycles(input int n);
        int a;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 4))
                0: a = 'h1FF0 + $urandom_range(0, 15);
                1: a = 'h1000 + $urandom_range(0, 255);
                2: a = $urandom_range(0, 'h1FFF);
                3: a = 'h0FF0 + $urandom_range(0, 15);
                default: a = 'h1000 + $urandom_range(0, 'hFFF);
            endcase
            bus(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 7) != 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) m_ram_v[i] = 1'b0;

        // F8 reset and switching
        do_reset(1, 1'b0);
        bus('h1000, 1'b1, 8'h00, 1'b1);
        bus('h1FF8, 1'b1, 8'h00, 1'b1);
        chk("f8_bank0", bank, 0);
        bus('h1000, 1'b1, 8'h00, 1'b1);
        bus('h1FF9, 1'b1, 8'h00, 1'b1);
        chk("f8_bank1", bank, 1);
        bus('h1005, 1'b0, 8'h77, 1'b1);
        bus('h1085, 1'b1, 8'h00, 1'b1);

        // F4: every hotspot by write, then out-of-range and ce-less accesses
        do_reset(3, 1'b0);
        for (int h = 0; h < 8; h++) bus('h1FF4 + h, 1'b0, 8'h11, 1'b1);
        bus('h1FF8, 1'b1, 8'h00, 1'b1);
        bus('h1FFC, 1'b1, 8'h00, 1'b1);
        bus('h1FF5, 1'b1, 8'h00, 1'b0);
        chk("f4_noce", bank, 4);

        // Superchip on F6
        do_reset(2, 1'b1);
        bus('h1005, 1'b0, 8'hA5, 1'b1);
        bus('h1085, 1'b1, 8'h00, 1'b1);
        chk("sc_a5", rom_rdata, 8'hA5);
        bus('h1005, 1'b1, 8'h00, 1'b1);
        bus('h1085, 1'b0, 8'h3C, 1'b1);
        bus('h1085, 1'b1, 8'h00, 1'b1);
        chk("sc_keep", rom_rdata, 8'hA5);
        bus('h0FF8, 1'b0, 8'h99, 1'b1);
        bus('h0005, 1'b0, 8'h99, 1'b1);
        bus('h1085, 1'b1, 8'h00, 1'b1);

        // Reset mid-run beats a simultaneous hotspot strobe
        bus('h1FF6, 1'b1, 8'h00, 1'b1);
        cpu_addr = 13'h1FF8;
        cpu_rwn  = 1'b1;
        mapper   = 3'd3;
        reset    = 1'b1;
        cpu_ce   = 1'b1;
        @(negedge clk);
        cpu_ce = 1'b0;
        @(negedge clk);
        chk("mid_rst_bank", bank, 7);
        reset  = 1'b0;
        mapper = 3'd1;
        sc_en  = 1'b0;
        m_map  = 3;
        m_bank = 7;
        bus('h1FF4, 1'b1, 8'h00, 1'b1);
        chk("still_f4", bank, 0);
        bus('h1FF9, 1'b1, 8'h00, 1'b1);
        bus('h1085, 1'b1, 8'h00, 1'b1);

        // Randomized traffic across mapper configurations
        do_reset(1, 1'b1);
        rand_cycles(60);
        do_reset(2, 1'b1);
        rand_cycles(60);
        do_reset(3, 1'b1);
        rand_cycles(80);
        do_reset(0, 1'b1);
        rand_cycles(40);
        do_reset(5, 1'b0);
        rand_cycles(40);
        do_reset(6, 1'b1);
        rand_cycles(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
